pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 3, meaning pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning hit counter width in bits; legal range 1..32.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, which samples x on the current edge when high.
REQ-006 The block SHALL have port x, input, 1, the serial data bit.
REQ-007 The block SHALL have port pattern, input, PAT_W, the target sequence; pattern[PAT_W-1] is the oldest (first) bit and pattern[0] is the newest bit.
REQ-008 The block SHALL have port overlap, input, 1, selecting overlapping detection when high and non-overlapping detection when low.
REQ-009 The block SHALL have port clear, input, 1, a synchronous clear of the history, fill and counter.
REQ-010 The block SHALL have port z, output, 1, a combinational (Mealy) match flag.
REQ-011 The block SHALL have port z_q, output, 1, which is z registered one cycle later.
REQ-012 The block SHALL have port hit_count, output, CNT_W, a saturating match count.

Function
REQ-013 The block SHALL hold a history register hist of PAT_W-1 bits, where hist[0] is the most recent sample.
REQ-014 The block SHALL hold a fill counter that saturates at PAT_W-1.
REQ-015 z SHALL equal en & ~clear & (fill == PAT_W-1) & ({hist, x} == pattern), evaluated in the same cycle with zero latency.
REQ-016 On a rising edge with en=1 and clear=0, hist SHALL shift left with x entering at bit 0.
REQ-017 On a rising edge with en=1, clear=0 and z=0, fill SHALL increment, saturating at PAT_W-1.
REQ-018 On a rising edge with z=1 and overlap=1, fill SHALL be unchanged, so that suffixes of a match may begin the next match.
REQ-019 On a rising edge with z=1 and overlap=0, fill SHALL be set to 0, so that the next match needs PAT_W fresh samples.
REQ-020 With en=0, hist, fill and hit_count SHALL hold their values and z SHALL be 0.
REQ-021 No match SHALL be reported before PAT_W samples have been taken since reset, clear or a non-overlap match.
REQ-022 On a rising edge with z=1, hit_count SHALL increment; at all-ones it SHALL hold (saturate, never wrap).
REQ-023 clear=1 SHALL have priority over en: on that edge hist, fill and hit_count SHALL become 0, and z SHALL read 0 in that cycle.
REQ-024 A change on pattern or overlap SHALL take effect in the same cycle, with no state flush.
REQ-025 z_q SHALL be registered from z on every rising edge, independent of en.

Reset
REQ-026 While reset_n=0, asynchronously: hist=0, fill=0, hit_count=0, z_q=0.
REQ-027 z SHALL be 0 during reset, because fill is 0.
REQ-028 Reset asserted mid-stream SHALL discard partial matches; detection SHALL restart as after power-up.
REQ-029 Reset release SHALL take effect on the first rising edge after reset_n rises.

Configuration
REQ-030 With macro PATDET_COUNT_EN defined, the hit_count register and the saturation logic SHALL be built as specified.
REQ-031 With PATDET_COUNT_EN undefined, no counter logic SHALL be built, hit_count SHALL be tied to 0, and z/z_q behaviour SHALL be unchanged.

Verification
REQ-032 Overlap scenario: PAT_W=3, pattern=101, overlap=1, en=1, x stream 1,0,1,0,1 -> z=1 on samples 3 and 5 only; hit_count=2; z_q=1 one cycle after each hit.
REQ-033 Non-overlap scenario: same stream with overlap=0 -> z=1 on sample 3 only; then x=0,1 (samples 6,7) -> z=1 on sample 7; hit_count=2.
REQ-034 Enable-gap scenario: pattern=101, x=1 en=1, x=0 en=1, then three cycles en=0 (x toggling), then x=1 en=1 -> z=1 on the final sample; no z during the en=0 cycles.
REQ-035 Reset scenario: after samples 1,0 assert reset_n=0 for 1 cycle, release, then x=1 -> z=0; 0,1 -> z=1 on the third post-reset sample.
REQ-036 Saturation scenario: CNT_W=2, 5 hits -> hit_count=3 thereafter; clear=1 with en=1 and a matching x -> z=0 and hit_count=0 next cycle.
REQ-037 Macro-off scenario: PATDET_COUNT_EN undefined, any stream -> hit_count=0 constantly; z identical to the macro-on run.

Source files
------------

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: Mealy match flag z, registered z_q and a saturating hit counter.
// Define PATDET_COUNT_EN to build the hit counter; otherwise hit_count is tied to 0.
module pattern_detector #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] hit_count
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;

  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] v);
    return (v == FILL_MAX) ? v : v + FILL_W'(1);
  endfunction

  // Window is the stored history plus the bit arriving this cycle, oldest bit on the left.
  assign window = {hist, x};
  assign z      = en & ~clear & (fill == FILL_MAX) & (window == pattern);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= window[PAT_W-2:0];
      // Overlapping mode keeps fill full so a match suffix can seed the next match.
      if (z) fill <= overlap ? fill : '0;
      else   fill <= fill_sat_inc(fill);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) z_q <= 1'b0;
    else          z_q <= z;
  end

`ifdef PATDET_COUNT_EN
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (z)     cnt <= cnt_sat_inc(cnt);
  end

  assign hit_count = cnt;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed self-checking bench for pattern_detector (PAT_W=3, CNT_W=2).
module tb_pattern_detector;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic       x;
  logic [2:0] pattern;
  logic       overlap;
  logic       clear;
  logic       z;
  logic       z_q;
  logic [1:0] hit_count;

  int n_cmp = 0;
  int n_err = 0;

  pattern_detector #(.PAT_W(3), .CNT_W(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .x         (x),
    .pattern   (pattern),
    .overlap   (overlap),
    .clear     (clear),
    .z         (z),
    .z_q       (z_q),
    .hit_count (hit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int c);
`ifdef PATDET_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle starting just after a rising edge; z checked mid-cycle, z_q/hit_count after the edge.
  task automatic step(input string tag, input logic e, input logic b, input logic c,
                      input logic ez, input int ecnt);
    en = e; x = b; clear = c;
    @(negedge clock);
    check({tag, ".z"}, int'(z), int'(ez));
    @(posedge clock);
    #1;
    check({tag, ".z_q"}, int'(z_q), int'(ez));
    check({tag, ".cnt"}, int'(hit_count), cnt_exp(ecnt));
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; x = 1'b1; clear = 1'b0;
    pattern = 3'b101; overlap = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst.z",    int'(z), 0);
    check("rst.z_q",  int'(z_q), 0);
    check("rst.cnt",  int'(hit_count), 0);
    reset_n = 1'b1;
    en = 1'b0;
    @(posedge clock);
    #1;

    // Overlapping detection of 101 on 1,0,1,0,1
    step("ov1", 1, 1, 0, 0, 0);
    step("ov2", 1, 0, 0, 0, 0);
    step("ov3", 1, 1, 0, 1, 1);
    step("ov4", 1, 0, 0, 0, 1);
    step("ov5", 1, 1, 0, 1, 2);
    step("ovclr", 0, 0, 1, 0, 0);

    // Non-overlapping detection on 1,0,1,0,1,0,1
    overlap = 1'b0;
    step("no1", 1, 1, 0, 0, 0);
    step("no2", 1, 0, 0, 0, 0);
    step("no3", 1, 1, 0, 1, 1);
    step("no4", 1, 0, 0, 0, 1);
    step("no5", 1, 1, 0, 0, 1);
    step("no6", 1, 0, 0, 0, 1);
    step("no7", 1, 1, 0, 1, 2);
    step("noclr", 0, 0, 1, 0, 0);

    // Enable gap: en=0 cycles must neither sample nor flag
    step("eg1", 1, 1, 0, 0, 0);
    step("eg2", 1, 0, 0, 0, 0);
    step("eg3", 0, 1, 0, 0, 0);
    step("eg4", 0, 0, 0, 0, 0);
    step("eg5", 0, 1, 0, 0, 0);
    step("eg6", 1, 1, 0, 1, 1);
    step("egclr", 0, 0, 1, 0, 0);

    // Saturation with CNT_W=2: five overlapping hits, count sticks at 3
    overlap = 1'b1;
    step("sa1",  1, 1, 0, 0, 0);
    step("sa2",  1, 0, 0, 0, 0);
    step("sa3",  1, 1, 0, 1, 1);
    step("sa4",  1, 0, 0, 0, 1);
    step("sa5",  1, 1, 0, 1, 2);
    step("sa6",  1, 0, 0, 0, 2);
    step("sa7",  1, 1, 0, 1, 3);
    step("sa8",  1, 0, 0, 0, 3);
    step("sa9",  1, 1, 0, 1, 3);
    step("sa10", 1, 0, 0, 0, 3);
    step("sa11", 1, 1, 0, 1, 3);
    step("sa12", 1, 0, 0, 0, 3);
    // Clear beats en even when x would complete a match
    step("saclr", 1, 1, 1, 0, 0);
    step("sapost", 1, 1, 0, 0, 0);
    step("sapost2", 1, 0, 0, 0, 0);
    step("saclr2", 0, 0, 1, 0, 0);

    // Pattern switch takes effect at once without flushing history
    pattern = 3'b110;
    step("pc1", 1, 1, 0, 0, 0);
    step("pc2", 1, 1, 0, 0, 0);
    step("pc3", 1, 0, 0, 1, 1);
    pattern = 3'b101;
    step("pc4", 1, 1, 0, 1, 2);

    // Asynchronous reset mid-stream, with z_q and count nonzero beforehand
    en = 1'b1; x = 1'b1; clear = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mrst.z",   int'(z), 0);
    check("mrst.z_q", int'(z_q), 0);
    check("mrst.cnt", int'(hit_count), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step("rs1", 1, 1, 0, 0, 0);
    step("rs2", 1, 0, 0, 0, 0);
    step("rs3", 1, 1, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
